tx_packet_arbiter: RTL



---
 rtl/tx_packet_arbiter_pkg.sv | 38 +++
 rtl/tx_packet_arbiter_if.sv | 40 ++++
 rtl/tx_packet_arbiter_rr_arbiter.sv | 50 +++++
 rtl/tx_packet_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/tx_packet_arbiter_pkg.sv
// Shared constants, state encoding and header helpers for the tx packet arbiter.
// Host software and the simulation bench use the same header layout defined here.
package tx_packet_arbiter_pkg;

  localparam logic [1:0] HDR_SYNC_DEFAULT = 2'b10;
  localparam int         HDR_SYNC_LSB     = 6;
  localparam int         HDR_ID_LSB       = 3;
  localparam int         HDR_LEN_LSB      = 0;
  localparam int         MAX_LEN          = 4;
  localparam int         ID_W             = 3;
  localparam int         LEN_W            = 3;
  localparam int         DATA_W           = 32;
  localparam int         BYTE_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DONE
  } arb_state_t;

  // Requests longer than the payload word are truncated to MAX_LEN bytes.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

  function automatic logic [BYTE_W-1:0] make_header(input logic [1:0]       sync,
                                                    input logic [ID_W-1:0]  id,
                                                    input logic [LEN_W-1:0] len);
    logic [BYTE_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_SYNC_LSB +: 2]    = sync;
    hdr[HDR_ID_LSB   +: ID_W] = id;
    hdr[HDR_LEN_LSB  +: LEN_W] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/tx_packet_arbiter_if.sv
// Request/ack bundle from the data sources plus the tx FIFO write port.
// master = sources and FIFO side, slave = arbiter side.
interface tx_packet_arbiter_if
  import tx_packet_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        ack;
  logic                    busy;
  logic [BYTE_W-1:0]       tx_fifo_wdata;
  logic                    tx_fifo_winc;
  logic                    tx_fifo_wfull;

  modport master (
    output req,
    output req_data,
    output req_len,
    output tx_fifo_wfull,
    input  ack,
    input  busy,
    input  tx_fifo_wdata,
    input  tx_fifo_winc
  );

  modport slave (
    input  req,
    input  req_data,
    input  req_len,
    input  tx_fifo_wfull,
    output ack,
    output busy,
    output tx_fifo_wdata,
    output tx_fifo_winc
  );

endinterface

// File: rtl/tx_packet_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping at N_REQ.
// The pointer moves past the served id only when advance is strobed.
module tx_packet_arbiter_rr_arbiter
  import tx_packet_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [ID_W-1:0]  advance_id,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid
);

  logic [ID_W-1:0]  ptr_q;
  logic [N_REQ-1:0] req_rot;
  int               idx;

  // Rotating the doubled vector puts the pointer position at bit 0, so the
  // lowest set bit of req_rot is the round-robin winner.
  always_comb begin
    req_rot     = N_REQ'({req, req} >> ptr_q);
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_REQ) begin
          idx = idx - N_REQ;
        end
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
    grant = grant_valid ? (N_REQ'(1) << grant_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (advance_id >= ID_W'(N_REQ - 1)) ? '0 : advance_id + 1'b1;
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Shares the tx FIFO write port between N_REQ packet sources: round-robin grant,
// one framing header byte, 0-4 payload bytes LSB first, then a one-cycle ack.
module tx_packet_arbiter
  import tx_packet_arbiter_pkg::*;
#(
  parameter int         N_REQ    = 3,
  parameter logic [1:0] HDR_SYNC = HDR_SYNC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  tx_packet_arbiter_if.slave  bus
);

  arb_state_t         state_q;
  logic [ID_W-1:0]    id_q;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  data_q;
  logic [1:0]         cnt_q;
  logic [N_REQ-1:0]   grant_oh_q;
  logic [N_REQ-1:0]   ack_q;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic [DATA_W-1:0]  sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic [1:0]         last_cnt;
  logic               wr_en;
  logic [BYTE_W-1:0]  wdata;

  tx_packet_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req),
    .advance     (state_q == ST_DONE),
    .advance_id  (id_q),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // One-hot mux of the granted source's payload and length.
  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_data = bus.req_data[DATA_W*i +: DATA_W];
        sel_len  = bus.req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  // Length 4 wraps to 0 in two bits, so cnt 3 is still the last byte.
  assign last_cnt = 2'(len_q - 3'd1);

  // Write strobe stays combinational so the FIFO's registered full flag gates
  // every byte in the same cycle; reset kills a write immediately.
  assign wr_en = ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD)) && !bus.tx_fifo_wfull;

  always_comb begin
    wdata = '0;
    case (state_q)
      ST_HEADER:  wdata = make_header(HDR_SYNC, id_q, len_q);
      ST_PAYLOAD: wdata = data_q[{cnt_q, 3'b000} +: BYTE_W];
      default:    wdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            id_q       <= grant_id;
            data_q     <= sel_data;
            len_q      <= clamp_len(sel_len);
            grant_oh_q <= grant;
            state_q    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (wr_en) begin
            cnt_q <= '0;
            if (len_q == '0) begin
              state_q <= ST_DONE;
              ack_q   <= grant_oh_q;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (wr_en) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == last_cnt) begin
              state_q <= ST_DONE;
              ack_q   <= grant_oh_q;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_fifo_winc  = wr_en && !rst;
  assign bus.tx_fifo_wdata = wdata;
  assign bus.ack           = ack_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule
